// File: rtl/write_back_stage.sv
// Write-back stage of the RV32I pipeline: extends load data, selects the rd write value
// and registers everything headed to the register file, PC redirect and hazard unit.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif

module write_back_stage #(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 5,
   parameter int PC_WIDTH    = 32,
   parameter int FUNCT_WIDTH = 3
) (
   input  logic                     wb_clk,
   input  logic                     wb_rst,
   input  logic [FUNCT_WIDTH-1:0]   wb_i_funct,
   input  logic [`OPCODE_WIDTH-1:0] wb_i_opcode,
   input  logic [DWIDTH-1:0]        wb_i_data_load,
   input  logic                     wb_i_we_rd,
   input  logic [AWIDTH-1:0]        wb_i_rd_addr,
   input  logic [DWIDTH-1:0]        wb_i_rd_data,
   input  logic [PC_WIDTH-1:0]      wb_i_pc,
   input  logic                     wb_i_change_pc,
   input  logic                     wb_i_ce,
   input  logic                     wb_i_stall,
   input  logic                     wb_i_flush,
   output logic                     wb_o_we_rd,
   output logic [AWIDTH-1:0]        wb_o_rd_addr,
   output logic [DWIDTH-1:0]        wb_o_rd_data,
   output logic [PC_WIDTH-1:0]      wb_o_next_pc,
   output logic                     wb_o_change_pc,
   output logic                     wb_o_ce,
   output logic                     wb_o_stall,
   output logic                     wb_o_flush,
   output logic [`OPCODE_WIDTH-1:0] wb_o_opcode,
   output logic [FUNCT_WIDTH-1:0]   wb_o_funct
);

   localparam int LOAD_WORD = 2;

   logic [DWIDTH-1:0] load_ext;
   logic [DWIDTH-1:0] rd_data_next;

   // Memory data arrives right-aligned, so only the upper bits need filling.
   always_comb begin
      load_ext = wb_i_data_load;
      case (wb_i_funct[2:0])
         3'b000:  load_ext = {{(DWIDTH-8){wb_i_data_load[7]}},   wb_i_data_load[7:0]};
         3'b001:  load_ext = {{(DWIDTH-16){wb_i_data_load[15]}}, wb_i_data_load[15:0]};
         3'b100:  load_ext = {{(DWIDTH-8){1'b0}},                wb_i_data_load[7:0]};
         3'b101:  load_ext = {{(DWIDTH-16){1'b0}},               wb_i_data_load[15:0]};
         default: load_ext = wb_i_data_load;
      endcase
   end

   always_comb begin
      rd_data_next = wb_i_rd_data;
      if (wb_i_opcode[LOAD_WORD]) begin
         rd_data_next = load_ext;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         wb_o_we_rd     <= 1'b0;
         wb_o_rd_addr   <= '0;
         wb_o_rd_data   <= '0;
         wb_o_next_pc   <= '0;
         wb_o_change_pc <= 1'b0;
         wb_o_ce        <= 1'b0;
         wb_o_stall     <= 1'b0;
         wb_o_flush     <= 1'b0;
         wb_o_opcode    <= '0;
         wb_o_funct     <= '0;
      end else if (wb_i_flush) begin
         // A flushed instruction is dropped even if ce is high.
         wb_o_we_rd     <= 1'b0;
         wb_o_change_pc <= 1'b0;
         wb_o_ce        <= 1'b0;
         wb_o_flush     <= 1'b1;
         wb_o_stall     <= wb_i_stall;
      end else if (wb_i_stall) begin
         wb_o_we_rd     <= 1'b0;
         wb_o_change_pc <= 1'b0;
         wb_o_stall     <= 1'b1;
         wb_o_ce        <= wb_i_ce;
         wb_o_flush     <= 1'b0;
      end else if (wb_i_ce) begin
         wb_o_rd_addr   <= wb_i_rd_addr;
         wb_o_rd_data   <= rd_data_next;
         wb_o_next_pc   <= wb_i_pc;
         wb_o_opcode    <= wb_i_opcode;
         wb_o_funct     <= wb_i_funct;
         wb_o_we_rd     <= wb_i_we_rd;
         wb_o_change_pc <= wb_i_change_pc;
         wb_o_ce        <= 1'b1;
         wb_o_stall     <= 1'b0;
         wb_o_flush     <= 1'b0;
      end else begin
         wb_o_we_rd     <= 1'b0;
         wb_o_change_pc <= 1'b0;
         wb_o_ce        <= 1'b0;
         wb_o_stall     <= 1'b0;
         wb_o_flush     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: one task per scenario, each with inline checks.
module tb_write_back_stage;

   localparam int OPW = 11;

   logic            wb_clk;
   logic            wb_rst;
   logic [2:0]      wb_i_funct;
   logic [OPW-1:0]  wb_i_opcode;
   logic [31:0]     wb_i_data_load;
   logic            wb_i_we_rd;
   logic [4:0]      wb_i_rd_addr;
   logic [31:0]     wb_i_rd_data;
   logic [31:0]     wb_i_pc;
   logic            wb_i_change_pc;
   logic            wb_i_ce;
   logic            wb_i_stall;
   logic            wb_i_flush;
   logic            wb_o_we_rd;
   logic [4:0]      wb_o_rd_addr;
   logic [31:0]     wb_o_rd_data;
   logic [31:0]     wb_o_next_pc;
   logic            wb_o_change_pc;
   logic            wb_o_ce;
   logic            wb_o_stall;
   logic            wb_o_flush;
   logic [OPW-1:0]  wb_o_opcode;
   logic [2:0]      wb_o_funct;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [OPW-1:0] OP_RTYPE = 11'b000_0000_0001;
   localparam logic [OPW-1:0] OP_LOAD  = 11'b000_0000_0100;

   write_back_stage dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_i_funct(wb_i_funct), .wb_i_opcode(wb_i_opcode),
      .wb_i_data_load(wb_i_data_load), .wb_i_we_rd(wb_i_we_rd), .wb_i_rd_addr(wb_i_rd_addr),
      .wb_i_rd_data(wb_i_rd_data), .wb_i_pc(wb_i_pc), .wb_i_change_pc(wb_i_change_pc),
      .wb_i_ce(wb_i_ce), .wb_i_stall(wb_i_stall), .wb_i_flush(wb_i_flush),
      .wb_o_we_rd(wb_o_we_rd), .wb_o_rd_addr(wb_o_rd_addr), .wb_o_rd_data(wb_o_rd_data),
      .wb_o_next_pc(wb_o_next_pc), .wb_o_change_pc(wb_o_change_pc), .wb_o_ce(wb_o_ce),
      .wb_o_stall(wb_o_stall), .wb_o_flush(wb_o_flush), .wb_o_opcode(wb_o_opcode),
      .wb_o_funct(wb_o_funct)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic drive(input logic ce, input logic stall, input logic flush,
                        input logic [OPW-1:0] op, input logic [2:0] f, input logic we,
                        input logic [4:0] addr, input logic [31:0] rdd,
                        input logic [31:0] ld, input logic [31:0] pc, input logic chg);
      wb_i_ce = ce; wb_i_stall = stall; wb_i_flush = flush; wb_i_opcode = op;
      wb_i_funct = f; wb_i_we_rd = we; wb_i_rd_addr = addr; wb_i_rd_data = rdd;
      wb_i_data_load = ld; wb_i_pc = pc; wb_i_change_pc = chg;
   endtask

   task automatic test_reset();
      wb_rst = 1'b1;
      drive(1, 0, 0, OP_LOAD, 3'b010, 1, 5'd7, 32'h5555_AAAA, 32'hDEAD_BEEF, 32'h100, 1);
      tick(); tick();
      n_checks++; if (wb_o_we_rd !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", wb_o_we_rd); end
      n_checks++; if (wb_o_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", wb_o_rd_addr); end
      n_checks++; if (wb_o_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", wb_o_rd_data); end
      n_checks++; if (wb_o_next_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", wb_o_next_pc); end
      n_checks++; if ({wb_o_change_pc, wb_o_ce, wb_o_stall, wb_o_flush} !== 4'b0000) begin n_fail++;
         $display("FAIL reset_ctrl got %b want 0000", {wb_o_change_pc, wb_o_ce, wb_o_stall, wb_o_flush}); end
      n_checks++; if ({wb_o_opcode, wb_o_funct} !== 14'd0) begin n_fail++; $display("FAIL reset_op got %h want 0", {wb_o_opcode, wb_o_funct}); end
      wb_rst = 1'b0;
      wb_i_ce = 1'b0;
      tick();
      n_checks++; if ({wb_o_ce, wb_o_we_rd, wb_o_rd_data} !== 34'd0) begin n_fail++;
         $display("FAIL post_reset_idle got ce=%0b we=%0b data=%h want 0", wb_o_ce, wb_o_we_rd, wb_o_rd_data); end
      $display("txn reset: done");
   endtask

   task automatic test_lw();
      drive(1, 0, 0, OP_LOAD, 3'b010, 1, 5'd10, 32'h0, 32'hDEAD_BEEF, 32'h40, 1);
      tick();
      n_checks++; if (wb_o_we_rd !== 1'b1) begin n_fail++; $display("FAIL lw_we got %0b want 1", wb_o_we_rd); end
      n_checks++; if (wb_o_rd_addr !== 5'd10) begin n_fail++; $display("FAIL lw_addr got %0d want 10", wb_o_rd_addr); end
      n_checks++; if (wb_o_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data got %h want deadbeef", wb_o_rd_data); end
      n_checks++; if (wb_o_next_pc !== 32'h40) begin n_fail++; $display("FAIL lw_pc got %h want 40", wb_o_next_pc); end
      n_checks++; if ({wb_o_change_pc, wb_o_ce, wb_o_stall, wb_o_flush} !== 4'b1100) begin n_fail++;
         $display("FAIL lw_ctrl got %b want 1100", {wb_o_change_pc, wb_o_ce, wb_o_stall, wb_o_flush}); end
      n_checks++; if (wb_o_opcode !== OP_LOAD || wb_o_funct !== 3'b010) begin n_fail++;
         $display("FAIL lw_op got op=%h f=%b want op=%h f=010", wb_o_opcode, wb_o_funct, OP_LOAD); end
      $display("txn lw: rd_data=%h", wb_o_rd_data);
   endtask

   task automatic test_load_ext();
      logic [2:0]  f_tab [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011, 3'b110};
      logic [31:0] e_tab [6] = '{32'hFFFF_FFEF, 32'h0000_00EF, 32'hFFFF_BEEF, 32'h0000_BEEF,
                                 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, OP_LOAD, f_tab[i], 1, 5'd11, 32'h0, 32'hDEAD_BEEF, 32'h44, 0);
         tick();
         n_checks++; if (wb_o_rd_data !== e_tab[i]) begin n_fail++;
            $display("FAIL load_ext_f%b got %h want %h", f_tab[i], wb_o_rd_data, e_tab[i]); end
         $display("txn load_ext funct=%b rd_data=%h", f_tab[i], wb_o_rd_data);
      end
      // Sign bit clear: LB of 0x7F must not extend with ones.
      drive(1, 0, 0, OP_LOAD, 3'b000, 1, 5'd11, 32'h0, 32'hFFFF_FF7F, 32'h48, 0);
      tick();
      n_checks++; if (wb_o_rd_data !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_pos got %h want 0000007f", wb_o_rd_data); end
      $display("txn lb_pos rd_data=%h", wb_o_rd_data);
   endtask

   task automatic test_alu();
      drive(1, 0, 0, OP_RTYPE, 3'b000, 1, 5'd12, 32'h1234_5678, 32'hDEAD_BEEF, 32'h4C, 0);
      tick();
      n_checks++; if (wb_o_rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_data got %h want 12345678", wb_o_rd_data); end
      n_checks++; if (wb_o_we_rd !== 1'b1 || wb_o_change_pc !== 1'b0) begin n_fail++;
         $display("FAIL alu_ctrl got we=%0b chg=%0b want we=1 chg=0", wb_o_we_rd, wb_o_change_pc); end
      $display("txn alu rd_data=%h", wb_o_rd_data);
   endtask

   task automatic test_ce_low();
      drive(0, 0, 0, OP_LOAD, 3'b010, 1, 5'd20, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h80, 1);
      tick();
      n_checks++; if ({wb_o_we_rd, wb_o_ce, wb_o_change_pc, wb_o_stall, wb_o_flush} !== 5'b0) begin n_fail++;
         $display("FAIL ce_low_ctrl got %b want 00000", {wb_o_we_rd, wb_o_ce, wb_o_change_pc, wb_o_stall, wb_o_flush}); end
      n_checks++; if (wb_o_rd_data !== 32'h1234_5678 || wb_o_rd_addr !== 5'd12) begin n_fail++;
         $display("FAIL ce_low_hold got %h/%0d want 12345678/12", wb_o_rd_data, wb_o_rd_addr); end
      $display("txn ce_low rd_data=%h", wb_o_rd_data);
   endtask

   task automatic test_stall();
      drive(1, 0, 0, OP_RTYPE, 3'b000, 1, 5'd3, 32'h1111, 32'h0, 32'h90, 0);
      tick();
      drive(1, 1, 0, OP_RTYPE, 3'b000, 1, 5'd4, 32'h2222, 32'h0, 32'h94, 1);
      tick();
      n_checks++; if ({wb_o_we_rd, wb_o_stall, wb_o_ce, wb_o_flush, wb_o_change_pc} !== 5'b01100) begin n_fail++;
         $display("FAIL stall_ctrl got %b want 01100", {wb_o_we_rd, wb_o_stall, wb_o_ce, wb_o_flush, wb_o_change_pc}); end
      n_checks++; if (wb_o_rd_data !== 32'h1111 || wb_o_rd_addr !== 5'd3 || wb_o_next_pc !== 32'h90) begin n_fail++;
         $display("FAIL stall_hold got %h/%0d/%h want 1111/3/90", wb_o_rd_data, wb_o_rd_addr, wb_o_next_pc); end
      $display("txn stall rd_data=%h", wb_o_rd_data);
   endtask

   task automatic test_flush();
      drive(1, 1, 1, OP_RTYPE, 3'b000, 1, 5'd5, 32'h3333, 32'h0, 32'hA0, 1);
      tick();
      n_checks++; if ({wb_o_flush, wb_o_ce, wb_o_we_rd, wb_o_stall, wb_o_change_pc} !== 5'b10010) begin n_fail++;
         $display("FAIL flush_stall_ctrl got %b want 10010", {wb_o_flush, wb_o_ce, wb_o_we_rd, wb_o_stall, wb_o_change_pc}); end
      n_checks++; if (wb_o_rd_data !== 32'h1111) begin n_fail++; $display("FAIL flush_stall_hold got %h want 1111", wb_o_rd_data); end
      drive(1, 0, 1, OP_LOAD, 3'b010, 1, 5'd6, 32'h4444, 32'h5555, 32'hA4, 1);
      tick();
      n_checks++; if ({wb_o_flush, wb_o_ce, wb_o_we_rd, wb_o_stall, wb_o_change_pc} !== 5'b10000) begin n_fail++;
         $display("FAIL flush_ce_ctrl got %b want 10000", {wb_o_flush, wb_o_ce, wb_o_we_rd, wb_o_stall, wb_o_change_pc}); end
      n_checks++; if (wb_o_rd_data !== 32'h1111 || wb_o_opcode !== OP_RTYPE) begin n_fail++;
         $display("FAIL flush_ce_hold got %h/%h want 1111/%h", wb_o_rd_data, wb_o_opcode, OP_RTYPE); end
      $display("txn flush flush=%0b ce=%0b", wb_o_flush, wb_o_ce);
   endtask

   task automatic test_back_to_back();
      logic [4:0]  a_tab [3] = '{5'd0, 5'd17, 5'd31};
      logic [31:0] d_tab [3] = '{32'hCAFE_0000, 32'h0BAD_F00D, 32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, OP_RTYPE, 3'b000, 1, a_tab[i], d_tab[i], 32'h0, 32'hC0 + 32'(i * 4), 0);
         tick();
         n_checks++; if (wb_o_rd_addr !== a_tab[i] || wb_o_rd_data !== d_tab[i] || wb_o_we_rd !== 1'b1 || wb_o_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_%0d got addr=%0d data=%h we=%0b ce=%0b want addr=%0d data=%h we=1 ce=1",
                     i, wb_o_rd_addr, wb_o_rd_data, wb_o_we_rd, wb_o_ce, a_tab[i], d_tab[i]);
         end
         $display("txn b2b %0d addr=%0d rd_data=%h", i, wb_o_rd_addr, wb_o_rd_data);
      end
      // Reset mid-stream overrides an active ce.
      wb_rst = 1'b1;
      tick();
      n_checks++; if ({wb_o_we_rd, wb_o_ce, wb_o_rd_data} !== 34'd0) begin n_fail++;
         $display("FAIL mid_reset got we=%0b ce=%0b data=%h want 0", wb_o_we_rd, wb_o_ce, wb_o_rd_data); end
      wb_rst = 1'b0;
      tick();
      n_checks++; if (wb_o_rd_data !== 32'hFFFF_FFFF || wb_o_ce !== 1'b1) begin n_fail++;
         $display("FAIL post_reset_capture got data=%h ce=%0b want ffffffff/1", wb_o_rd_data, wb_o_ce); end
      $display("txn mid_reset rd_data=%h", wb_o_rd_data);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_alu();
      test_ce_low();
      test_stall();
      test_flush();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Final (write-back) stage of the five-stage RV32I pipeline. Takes the memory-stage result and load data and selects the register-file write value. Load data is sign- or zero-extended per funct3. Outputs are registered, with one cycle of latency, and drive the register-file write port, the PC-redirect path and the hazard/forwarding unit.

## Interface
Parameters:
- DWIDTH, 32: data width
- AWIDTH, 5: register address width
- PC_WIDTH, 32: PC width
- FUNCT_WIDTH, 3: funct3 width

Shared header macros:
- `OPCODE_WIDTH = 11: one-hot opcode bit indices
- RTYPE=0, ITYPE=1, LOAD_WORD=2, STORE_WORD=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, SYSTEM=9, FENCE=10

Ports. One clock; reset is synchronous and active-high.
- wb_clk, in, 1: clock; all state updates on its rising edge
- wb_rst, in, 1: synchronous active-high reset
- wb_i_funct, in, FUNCT_WIDTH: funct3 of the instruction
- wb_i_opcode, in, `OPCODE_WIDTH: one-hot opcode
- wb_i_data_load, in, DWIDTH: raw memory read data, already right-aligned
- wb_i_we_rd, in, 1: instruction writes rd
- wb_i_rd_addr, in, AWIDTH: destination register
- wb_i_rd_data, in, DWIDTH: ALU/PC-link result
- wb_i_pc, in, PC_WIDTH: next-PC value from earlier stage
- wb_i_change_pc, in, 1: PC redirect request
- wb_i_ce, in, 1: stage input valid
- wb_i_stall, in, 1: pipeline stall
- wb_i_flush, in, 1: pipeline flush
- wb_o_we_rd, out, 1: register-file write enable
- wb_o_rd_addr, out, AWIDTH: register-file write address
- wb_o_rd_data, out, DWIDTH: register-file write data
- wb_o_next_pc, out, PC_WIDTH: registered wb_i_pc
- wb_o_change_pc, out, 1: registered redirect
- wb_o_ce, out, 1: registered valid
- wb_o_stall, out, 1: registered stall
- wb_o_flush, out, 1: registered flush
- wb_o_opcode, out, `OPCODE_WIDTH: registered opcode
- wb_o_funct, out, FUNCT_WIDTH: registered funct3

## Operation
Write-data select (combinational, then registered):
- opcode[LOAD_WORD]=1 → extended load data; otherwise wb_i_rd_data.

Load extension by funct3:
- 000 LB: sign-extend bits [7:0]
- 001 LH: sign-extend bits [15:0]
- 010 LW: full 32 bits
- 100 LBU: zero-extend bits [7:0]
- 101 LHU: zero-extend bits [15:0]
- any other funct3: full 32 bits

Register update priority, evaluated each rising edge:
1. wb_rst=1: every output ← 0.
2. wb_i_flush=1:
   - wb_o_we_rd, wb_o_change_pc, wb_o_ce ← 0
   - wb_o_flush ← 1
   - wb_o_stall ← wb_i_stall
   - data/addr/pc/opcode/funct hold
3. wb_i_stall=1:
   - wb_o_we_rd, wb_o_change_pc ← 0
   - wb_o_stall ← 1
   - wb_o_ce ← wb_i_ce
   - wb_o_flush ← 0
   - remaining registers hold
4. wb_i_ce=1:
   - capture rd_addr, selected rd_data, pc, opcode, funct
   - wb_o_we_rd ← wb_i_we_rd
   - wb_o_change_pc ← wb_i_change_pc
   - wb_o_ce ← 1
   - stall/flush outputs ← 0
5. wb_i_ce=0:
   - wb_o_we_rd, wb_o_change_pc, wb_o_ce ← 0
   - stall/flush outputs ← 0
   - data registers hold

Other rules:
- Writes to rd_addr 0 pass through unchanged; the register file ignores x0.
- wb_o_we_rd is never 1 unless wb_o_ce is 1.

## Timing
- Latency: exactly 1 cycle from input sample edge to output.
- No handshake; ce is a per-cycle valid qualifier.
- Load data must be stable at the same edge ce/opcode are sampled.
- Reset mid-operation overrides all other inputs on that edge; first valid capture happens the edge after wb_rst deasserts.
- Simultaneous flush and stall: flush wins.
- Simultaneous flush and ce: the instruction is dropped.
- Back-to-back ce cycles each produce one output cycle with no bubble.

## Test plan
- Reset: hold wb_rst=1 for 2 cycles with nonzero inputs → all outputs 0; release → outputs still 0 until the first ce edge.
- LW: opcode=onehot(LOAD_WORD), funct=010, rd_addr=10, we=1, ce=1, data_load=0xDEADBEEF, change_pc=1, pc=0x40 → next edge: we_rd=1, rd_addr=10, rd_data=0xDEADBEEF, next_pc=0x40, change_pc=1, ce=1, stall=0, flush=0.
- Load extensions with data_load=0xDEADBEEF:
  - funct=000 (LB) → rd_data=0xFFFFFFEF
  - funct=100 (LBU) → 0x000000EF
  - funct=001 (LH) → 0xFFFFBEEF
  - funct=101 (LHU) → 0x0000BEEF
- ALU path: opcode=onehot(RTYPE), rd_data=0x12345678, data_load=0xDEADBEEF → rd_data=0x12345678.
- ce=0 after a valid cycle → next edge: we_rd=0, ce=0, change_pc=0, stall=0, flush=0, rd_data unchanged.
- Stall=1 with ce=1 → we_rd=0, stall=1, data held.
- Stall and flush both 1 → flush=1, ce=0, we_rd=0.
